mem_wb_writeback: RTL and testbench
===================================

Name: mem_wb_writeback

Overview:
MEM/WB pipeline stage placed directly upstream of the register file. It registers the memory-stage result, selects the writeback source (ALU, load data, link address) and extends sub-word loads. It drives the register file's write port (WriteData, WriteReg, RegWriteActive) from flops, so the register file sees glitch-free, one-cycle-stable write controls. It also exports a forwarding tap and a retired-instruction counter.

Parameters:
DATA_W, 32, datapath width
REG_ADDR_W, 5, register index width
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
Stall  in  1  hold all stage registers
Flush  in  1  replace incoming instruction with a bubble
ValidIn  in  1  MEM stage holds a real instruction
ALUResultIn  in  DATA_W  ALU result / load address
MemReadDataIn  in  DATA_W  raw word from data memory
PCPlus4In  in  DATA_W  link value for JAL/JALR
WriteRegIn  in  REG_ADDR_W  destination register
RegWriteIn  in  1  instruction writes a register
MemToRegIn  in  2  source select: 00 ALU, 01 MEM, 10 LINK, 11 reserved (treated as ALU)
LoadTypeIn  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, others treated as LW
WriteData  out  DATA_W  to register file write data
WriteReg  out  REG_ADDR_W  to register file write index
RegWriteActive  out  1  to register file write enable
ValidOut  out  1  WB stage holds a real instruction
FwdValid  out  1  forwarding tap valid (equals RegWriteActive)
FwdReg  out  REG_ADDR_W  equals WriteReg
FwdData  out  DATA_W  equals WriteData
InstRetired  out  CNT_W  count of instructions retired

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Every output is driven from a flop or is a direct copy of one; there is no combinational path from inputs to outputs.
- Reset: WriteData=0, WriteReg=0, RegWriteActive=0, ValidOut=0, InstRetired=0. Reset overrides Stall and Flush.
- Priority on each rising edge: reset > Flush > Stall > capture.
- Flush: ValidOut=0, RegWriteActive=0, WriteReg=0, WriteData=0. Flush wins when Stall is also asserted.
- Stall (no Flush): all registers, including InstRetired, hold their values. RegWriteActive stays asserted if it was set, so the rewrite of the same value is harmless.
- Capture: latency is 1 cycle, from MEM inputs to the outputs.
  - ValidOut <= ValidIn.
  - RegWriteActive <= ValidIn & RegWriteIn & (WriteRegIn != 0). Writes to $zero are suppressed.
  - WriteReg <= WriteRegIn when ValidIn, else 0.
  - WriteData <= mux(MemToRegIn) before the flop. The MEM source uses the extended load data.
- Load extension uses byte offset ALUResultIn[1:0], little-endian lanes:
  - LB/LBU: select byte[offset]; sign-extend or zero-extend.
  - LH/LHU: select half[offset[1]]; offset[0] is ignored (no misalignment trap).
  - LW: full word.
- InstRetired increments by 1 on each capture edge where ValidIn=1. It wraps modulo 2^CNT_W and does not increment on stall, flush or bubble.
- Reset asserted mid-stall clears everything in that cycle. The first valid capture after reset deasserts lands one cycle later.

Optional Feature:
- LOAD_EXT_EN defined: LB/LBU/LH/LHU extension as above.
- LOAD_EXT_EN undefined: LoadTypeIn is ignored and the MEM source is always MemReadDataIn unmodified (word-only MIPS subset); the extender is not instantiated.

Decomposition:
- Package mips_pkg holds:
  - MemToReg encodings: MTR_ALU, MTR_MEM, MTR_LINK.
  - LoadType encodings: LD_W, LD_B, LD_BU, LD_H, LD_HU.
  - Widths: DATA_W and REG_ADDR_W defaults.
- One combinational sub-module, load_extender (inputs: raw word, offset, load type; output: extended word), instantiated under LOAD_EXT_EN.

Test Plan:
- Reset sequence: hold reset 2 cycles with ValidIn=1 and RegWriteIn=1 -> all outputs 0. Release; capture ALU 0x0000_0004 to reg 1 -> next cycle WriteData=4, WriteReg=1, RegWriteActive=1, InstRetired=1.
- $zero suppression: ValidIn=1, RegWriteIn=1, WriteRegIn=0, ALU=0xDEAD_BEEF -> RegWriteActive=0, ValidOut=1, InstRetired increments.
- Load extension (LOAD_EXT_EN): MemReadDataIn=0x8012_F0A5, addr=0x...1 -> LB gives 0xFFFF_FFF0, LBU gives 0x0000_00F0. Addr=0x...2 -> LH gives 0xFFFF_8012, LHU gives 0x0000_8012. Without the macro, all four give 0x8012_F0A5.
- Link: MemToRegIn=10, PCPlus4In=0x0040_0008, WriteRegIn=31 -> WriteData=0x0040_0008, WriteReg=31.
- Stall/Flush: capture reg 5, then Stall 3 cycles with new inputs -> outputs and InstRetired frozen. Stall+Flush together -> bubble (RegWriteActive=0, ValidOut=0), no count.
- Counter wrap: with CNT_W=4, retire 17 valid instructions -> InstRetired=1.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings and default widths for the MIPS pipeline stages.
package mips_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    MTR_ALU  = 2'b00,
    MTR_MEM  = 2'b01,
    MTR_LINK = 2'b10
  } mem_to_reg_e;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_BU = 3'b010,
    LD_H  = 3'b011,
    LD_HU = 3'b100
  } load_type_e;

endpackage

// File: rtl/mem_wb_writeback_load_extender.sv
// load_extender: picks the addressed byte/half of a loaded word (little-endian lanes)
// and sign- or zero-extends it; unknown load types pass the full word through.
module load_extender
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] i_rawWord,
  input  logic [1:0]        i_offset,
  input  logic [2:0]        i_loadType,
  output logic [DATA_W-1:0] o_extWord
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfword loads ignore offset[0]; misaligned halves simply read the enclosing half.
  assign w_byte = i_rawWord[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_rawWord[31:16] : i_rawWord[15:0];

  always_comb begin
    o_extWord = i_rawWord;
    case (i_loadType)
      LD_B:    o_extWord = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LD_BU:   o_extWord = {{(DATA_W-8){1'b0}}, w_byte};
      LD_H:    o_extWord = {{(DATA_W-16){w_half[15]}}, w_half};
      LD_HU:   o_extWord = {{(DATA_W-16){1'b0}}, w_half};
      default: o_extWord = i_rawWord;
    endcase
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: MEM/WB stage register feeding the register-file write port from flops.
// Define LOAD_EXT_EN to enable LB/LBU/LH/LHU extension; otherwise loads are word-only.
module mem_wb_writeback
  import mips_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  ValidIn,
  input  logic [DATA_W-1:0]     ALUResultIn,
  input  logic [DATA_W-1:0]     MemReadDataIn,
  input  logic [DATA_W-1:0]     PCPlus4In,
  input  logic [REG_ADDR_W-1:0] WriteRegIn,
  input  logic                  RegWriteIn,
  input  logic [1:0]            MemToRegIn,
  input  logic [2:0]            LoadTypeIn,
  output logic [DATA_W-1:0]     WriteData,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic                  RegWriteActive,
  output logic                  ValidOut,
  output logic                  FwdValid,
  output logic [REG_ADDR_W-1:0] FwdReg,
  output logic [DATA_W-1:0]     FwdData,
  output logic [CNT_W-1:0]      InstRetired
);

  logic [DATA_W-1:0]     w_memData;
  logic [DATA_W-1:0]     w_wbData;
  logic                  w_regWrite;

  logic [DATA_W-1:0]     r_writeData;
  logic [REG_ADDR_W-1:0] r_writeReg;
  logic                  r_regWriteActive;
  logic                  r_validOut;
  logic [CNT_W-1:0]      r_instRetired;

`ifdef LOAD_EXT_EN
  load_extender #(
    .DATA_W(DATA_W)
  ) u_loadExtender (
    .i_rawWord (MemReadDataIn),
    .i_offset  (ALUResultIn[1:0]),
    .i_loadType(LoadTypeIn),
    .o_extWord (w_memData)
  );
`else
  logic [2:0] w_unusedLoadType;
  assign w_unusedLoadType = LoadTypeIn;
  assign w_memData        = MemReadDataIn;
`endif

  always_comb begin
    w_wbData = ALUResultIn;
    case (MemToRegIn)
      MTR_MEM:  w_wbData = w_memData;
      MTR_LINK: w_wbData = PCPlus4In;
      default:  w_wbData = ALUResultIn;
    endcase
  end

  // Writes to $zero never reach the register file.
  assign w_regWrite = ValidIn & RegWriteIn & (WriteRegIn != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_writeData      <= '0;
      r_writeReg       <= '0;
      r_regWriteActive <= 1'b0;
      r_validOut       <= 1'b0;
      r_instRetired    <= '0;
    end else if (Flush) begin
      r_writeData      <= '0;
      r_writeReg       <= '0;
      r_regWriteActive <= 1'b0;
      r_validOut       <= 1'b0;
    end else if (!Stall) begin
      r_writeData      <= w_wbData;
      r_writeReg       <= ValidIn ? WriteRegIn : '0;
      r_regWriteActive <= w_regWrite;
      r_validOut       <= ValidIn;
      if (ValidIn) begin
        r_instRetired <= r_instRetired + CNT_W'(1);
      end
    end
  end

  assign WriteData      = r_writeData;
  assign WriteReg       = r_writeReg;
  assign RegWriteActive = r_regWriteActive;
  assign ValidOut       = r_validOut;
  assign FwdValid       = r_regWriteActive;
  assign FwdReg         = r_writeReg;
  assign FwdData        = r_writeData;
  assign InstRetired    = r_instRetired;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb_mem_wb_writeback: directed plus randomized checks of the MEM/WB stage against a behavioural model.
// Honours LOAD_EXT_EN the same way the design does; the counter is built 4 bits wide to exercise wrap.
module tb_mem_wb_writeback;

  localparam int TB_CNT_W = 4;

`ifdef LOAD_EXT_EN
  localparam bit EXT_ENABLED = 1'b1;
`else
  localparam bit EXT_ENABLED = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        Stall;
  logic        Flush;
  logic        ValidIn;
  logic [31:0] ALUResultIn;
  logic [31:0] MemReadDataIn;
  logic [31:0] PCPlus4In;
  logic [4:0]  WriteRegIn;
  logic        RegWriteIn;
  logic [1:0]  MemToRegIn;
  logic [2:0]  LoadTypeIn;
  logic [31:0] WriteData;
  logic [4:0]  WriteReg;
  logic        RegWriteActive;
  logic        ValidOut;
  logic        FwdValid;
  logic [4:0]  FwdReg;
  logic [31:0] FwdData;
  logic [TB_CNT_W-1:0] InstRetired;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Reference state: what the register-file port should show after the next edge.
  logic [31:0] mWriteData;
  logic [4:0]  mWriteReg;
  logic        mRegWrite;
  logic        mValid;
  int unsigned mRetired;

  mem_wb_writeback #(
    .DATA_W    (32),
    .REG_ADDR_W(5),
    .CNT_W     (TB_CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Stall         (Stall),
    .Flush         (Flush),
    .ValidIn       (ValidIn),
    .ALUResultIn   (ALUResultIn),
    .MemReadDataIn (MemReadDataIn),
    .PCPlus4In     (PCPlus4In),
    .WriteRegIn    (WriteRegIn),
    .RegWriteIn    (RegWriteIn),
    .MemToRegIn    (MemToRegIn),
    .LoadTypeIn    (LoadTypeIn),
    .WriteData     (WriteData),
    .WriteReg      (WriteReg),
    .RegWriteActive(RegWriteActive),
    .ValidOut      (ValidOut),
    .FwdValid      (FwdValid),
    .FwdReg        (FwdReg),
    .FwdData       (FwdData),
    .InstRetired   (InstRetired)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Arithmetic view of a little-endian load: shift the lane down, mask, extend by value.
  function automatic logic [31:0] modelLoad(input logic [31:0] raw, input logic [1:0] off, input logic [2:0] lt);
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] ext;
    b = (raw >> (8 * off)) & 32'hFF;
    h = (raw >> (16 * off[1])) & 32'hFFFF;
    case (lt)
      3'd1:    ext = (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      3'd2:    ext = b;
      3'd3:    ext = (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    ext = h;
      default: ext = raw;
    endcase
    return EXT_ENABLED ? ext : raw;
  endfunction

  task automatic modelUpdate();
    if (reset) begin
      mWriteData = 0; mWriteReg = 0; mRegWrite = 0; mValid = 0; mRetired = 0;
    end else if (Flush) begin
      mWriteData = 0; mWriteReg = 0; mRegWrite = 0; mValid = 0;
    end else if (!Stall) begin
      mValid    = ValidIn;
      mRegWrite = ValidIn && RegWriteIn && (WriteRegIn != 0);
      mWriteReg = ValidIn ? WriteRegIn : 5'd0;
      if (MemToRegIn == 2'd1)      mWriteData = modelLoad(MemReadDataIn, ALUResultIn[1:0], LoadTypeIn);
      else if (MemToRegIn == 2'd2) mWriteData = PCPlus4In;
      else                         mWriteData = ALUResultIn;
      if (ValidIn) mRetired = (mRetired + 1) % (1 << TB_CNT_W);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic st, input logic fl, input logic v,
                               input logic rw, input logic [4:0] wr, input logic [1:0] mtr,
                               input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] mem,
                               input logic [31:0] pc);
    reset = rst; Stall = st; Flush = fl; ValidIn = v; RegWriteIn = rw; WriteRegIn = wr;
    MemToRegIn = mtr; LoadTypeIn = lt; ALUResultIn = alu; MemReadDataIn = mem; PCPlus4In = pc;
  endtask

  task automatic stepAndCheck(input string tag);
    modelUpdate();
    @(posedge clk);
    #1;
    checkOutput({tag, ".wd"},  WriteData,      mWriteData);
    checkOutput({tag, ".wr"},  {27'd0, WriteReg}, {27'd0, mWriteReg});
    checkOutput({tag, ".rwa"}, {31'd0, RegWriteActive}, {31'd0, mRegWrite});
    checkOutput({tag, ".vo"},  {31'd0, ValidOut}, {31'd0, mValid});
    checkOutput({tag, ".fv"},  {31'd0, FwdValid}, {31'd0, mRegWrite});
    checkOutput({tag, ".fr"},  {27'd0, FwdReg}, {27'd0, mWriteReg});
    checkOutput({tag, ".fd"},  FwdData,        mWriteData);
    checkOutput({tag, ".cnt"}, 32'(InstRetired), mRetired);
  endtask

  initial begin
    clk = 1'b0;
    mWriteData = 0; mWriteReg = 0; mRegWrite = 0; mValid = 0; mRetired = 0;

    // Reset held two cycles while a writing instruction is presented.
    applyStimulus(1, 0, 0, 1, 1, 5'd3, 2'd0, 3'd0, 32'h5555_5555, 32'h0, 32'h0);
    stepAndCheck("rst0");
    stepAndCheck("rst1");
    checkOutput("rst.wd", WriteData, 32'h0);
    checkOutput("rst.cnt", 32'(InstRetired), 32'h0);

    applyStimulus(0, 0, 0, 1, 1, 5'd1, 2'd0, 3'd0, 32'h0000_0004, 32'h0, 32'h0);
    stepAndCheck("first");
    checkOutput("first.wd", WriteData, 32'd4);
    checkOutput("first.wr", {27'd0, WriteReg}, 32'd1);
    checkOutput("first.rwa", {31'd0, RegWriteActive}, 32'd1);
    checkOutput("first.cnt", 32'(InstRetired), 32'd1);

    applyStimulus(0, 0, 0, 1, 1, 5'd0, 2'd0, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
    stepAndCheck("zero");
    checkOutput("zero.rwa", {31'd0, RegWriteActive}, 32'd0);
    checkOutput("zero.vo", {31'd0, ValidOut}, 32'd1);
    checkOutput("zero.cnt", 32'(InstRetired), 32'd2);

    applyStimulus(0, 0, 0, 1, 1, 5'd2, 2'd1, 3'd1, 32'h1000_0001, 32'h8012_F0A5, 32'h0);
    stepAndCheck("lb");
    checkOutput("lb.const", WriteData, EXT_ENABLED ? 32'hFFFF_FFF0 : 32'h8012_F0A5);
    applyStimulus(0, 0, 0, 1, 1, 5'd2, 2'd1, 3'd2, 32'h1000_0001, 32'h8012_F0A5, 32'h0);
    stepAndCheck("lbu");
    checkOutput("lbu.const", WriteData, EXT_ENABLED ? 32'h0000_00F0 : 32'h8012_F0A5);
    applyStimulus(0, 0, 0, 1, 1, 5'd2, 2'd1, 3'd3, 32'h1000_0002, 32'h8012_F0A5, 32'h0);
    stepAndCheck("lh");
    checkOutput("lh.const", WriteData, EXT_ENABLED ? 32'hFFFF_8012 : 32'h8012_F0A5);
    applyStimulus(0, 0, 0, 1, 1, 5'd2, 2'd1, 3'd4, 32'h1000_0002, 32'h8012_F0A5, 32'h0);
    stepAndCheck("lhu");
    checkOutput("lhu.const", WriteData, EXT_ENABLED ? 32'h0000_8012 : 32'h8012_F0A5);

    applyStimulus(0, 0, 0, 1, 1, 5'd31, 2'd2, 3'd0, 32'h1234_5678, 32'h0, 32'h0040_0008);
    stepAndCheck("link");
    checkOutput("link.wd", WriteData, 32'h0040_0008);
    checkOutput("link.wr", {27'd0, WriteReg}, 32'd31);

    // Capture reg 5, then stall with fresh inputs: everything must freeze.
    applyStimulus(0, 0, 0, 1, 1, 5'd5, 2'd0, 3'd0, 32'hA5A5_0005, 32'h0, 32'h0);
    stepAndCheck("cap5");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 1, 1, 5'(9 + i), 2'd0, 3'd0, 32'h0BAD_0000 + i, 32'h0, 32'h0);
      stepAndCheck($sformatf("stall%0d", i));
      checkOutput($sformatf("stall%0d.wd", i), WriteData, 32'hA5A5_0005);
      checkOutput($sformatf("stall%0d.rwa", i), {31'd0, RegWriteActive}, 32'd1);
    end
    applyStimulus(0, 1, 1, 1, 1, 5'd7, 2'd0, 3'd0, 32'h7777_7777, 32'h0, 32'h0);
    stepAndCheck("stallflush");
    checkOutput("stallflush.vo", {31'd0, ValidOut}, 32'd0);
    checkOutput("stallflush.rwa", {31'd0, RegWriteActive}, 32'd0);

    // Reset during a stall clears the stage and the counter.
    applyStimulus(1, 1, 0, 1, 1, 5'd4, 2'd0, 3'd0, 32'h4444_4444, 32'h0, 32'h0);
    stepAndCheck("rststall");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 5'(i % 32), 2'd0, 3'd0, 32'(i), 32'h0, 32'h0);
      stepAndCheck($sformatf("wrap%0d", i));
    end
    checkOutput("wrap.cnt", 32'(InstRetired), 32'd1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) < 3, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                    2'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
      stepAndCheck($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
